// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, computes the
// result at launch into pending registers, and commits it when the busy counter expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic          r_pend_we;

  logic [63:0] w_smul, w_umul;
  logic        w_div_zero;
  logic [31:0] w_a_mag, w_b_mag, w_b_nz, w_rt_nz;
  logic [31:0] w_q_mag, w_r_mag, w_sq, w_sr, w_uq, w_ur;

  // Low 64 bits of the sign-extended product equal the signed product.
  assign w_smul = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign w_umul = {32'd0, rs_data} * {32'd0, rt_data};

  assign w_div_zero = (rt_data == 32'd0);
  assign w_a_mag    = rs_data[31] ? (32'd0 - rs_data) : rs_data;
  assign w_b_mag    = rt_data[31] ? (32'd0 - rt_data) : rt_data;
  // Divisor forced nonzero so the divider never sees x/0; the result is discarded anyway.
  assign w_b_nz     = w_div_zero ? 32'd1 : w_b_mag;
  assign w_rt_nz    = w_div_zero ? 32'd1 : rt_data;
  assign w_q_mag    = w_a_mag / w_b_nz;
  assign w_r_mag    = w_a_mag % w_b_nz;
  assign w_sq       = (rs_data[31] ^ rt_data[31]) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_sr       = rs_data[31] ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_uq       = rs_data / w_rt_nz;
  assign w_ur       = rs_data % w_rt_nz;

  assign busy = (r_cnt != '0);
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    out = 32'd0;
    case (mdu_op)
      OP_MFHI: out = r_hi;
      OP_MFLO: out = r_lo;
      default: out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else if (busy) begin
      // Requests arriving while busy are dropped; only the countdown advances.
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1) && r_pend_we) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (start) begin
      case (mdu_op)
        OP_MULT: begin
          r_pend_hi <= w_smul[63:32];
          r_pend_lo <= w_smul[31:0];
          r_pend_we <= 1'b1;
          r_cnt     <= CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          r_pend_hi <= w_umul[63:32];
          r_pend_lo <= w_umul[31:0];
          r_pend_we <= 1'b1;
          r_cnt     <= CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          r_pend_hi <= w_sr;
          r_pend_lo <= w_sq;
          r_pend_we <= ~w_div_zero;
          r_cnt     <= CW'(DIV_CYCLES);
        end
        OP_DIVU: begin
          r_pend_hi <= w_ur;
          r_pend_lo <= w_uq;
          r_pend_we <= ~w_div_zero;
          r_cnt     <= CW'(DIV_CYCLES);
        end
        OP_MTHI: r_hi <= rs_data;
        OP_MTLO: r_lo <= rs_data;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: table of arithmetic vectors checked through a result
// scoreboard, plus hand sequences for div-by-zero, start-while-busy and mid-op reset.
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] rs_data = 32'd0, rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi, lo, out;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  res_t sb[$];
  vec_t vecs[7];
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input int elapsed);
    int  c;
    bit  held;
    res_t r;
    c = elapsed;
    held = 1'b1;
    while (busy === 1'b1 && c < 200) begin
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    check({name, "_hold"}, 32'(held), 32'd1);
    check({name, "_busy_len"}, 32'(c), 32'(exp_cyc));
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      r = sb.pop_front();
      check({name, "_hi"}, hi, r.h);
      check({name, "_lo"}, lo, r.l);
      m_hi = r.h; m_lo = r.l;
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{4'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[5] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_out", out, 32'd0);

    issue(4'd5, 32'hDEADBEEF, 32'd0);
    m_hi = 32'hDEADBEEF;
    check("mthi_busy", 32'(busy), 32'd0);
    mdu_op = 4'd7; #1;
    check("mfhi_out", out, 32'hDEADBEEF);
    mdu_op = 4'd9; #1;
    check("op9_out", out, 32'd0);
    issue(4'd6, 32'd5, 32'd0);
    m_lo = 32'd5;
    mdu_op = 4'd8; #1;
    check("mflo_out", out, 32'd5);
    mdu_op = 4'd0; #1;
    check("none_out", out, 32'd0);

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].exp_hi, vecs[i].exp_lo});
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done($sformatf("vec%0d", i), vecs[i].cyc, 0);
    end

    // Divide by zero leaves preloaded HI/LO untouched.
    issue(4'd5, 32'h11, 32'd0);
    issue(4'd6, 32'h22, 32'd0);
    m_hi = 32'h11; m_lo = 32'h22;
    sb.push_back('{32'h11, 32'h22});
    issue(4'd4, 32'd7, 32'd0);
    wait_done("divu0", 10, 0);

    // A DIV issued in busy cycle 2 of a MULT must be dropped.
    sb.push_back('{32'd0, 32'd42});
    issue(4'd1, 32'd6, 32'd7);
    @(posedge clk); #1;
    issue(4'd3, 32'd100, 32'd3);
    wait_done("mult_ign", 5, 2);
    ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) ok = 1'b0;
    end
    check("ign_div_quiet", 32'(ok), 32'd1);

    // Reset between edges in busy cycle 4 of a DIV.
    issue(4'd3, 32'd100, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk) reset = 1'b0;
    ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
    end
    check("midrst_no_commit", 32'(ok), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and produces the mfhi/mflo result. That result is the input the E-stage result selector does not cover.
- Executes mult/multu/div/divu with fixed latency and handles mthi/mtlo writes.
- Exposes busy so the hazard unit stalls dependent MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  E-stage instruction valid and not flushed. Qualifies mdu_op for ops 1-6.
- mdu_op  input  4  operation code:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
  - 9-15 are treated as NONE.
- rs_data  input  32  operand A; also the mthi/mtlo source.
- rt_data  input  32  operand B.
- busy  output  1  operation in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- out  output  32  read result: hi when mdu_op=MFHI, lo when mdu_op=MFLO, else 0. Combinational.

Behaviour:
- Reset (async, high):
  - hi=0, lo=0, busy=0.
  - Cycle counter=0; pending result registers=0.
  - Any in-flight operation is discarded; HI/LO are never written with its result.
- Launch:
  - Condition: rising edge with start=1, busy=0, and mdu_op in 1..4.
  - Operands are latched and the full result is computed into pending registers (pend_hi, pend_lo).
  - Counter is loaded with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
- busy:
  - busy = (counter != 0). It rises the cycle after the launch edge.
  - It stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- Commit:
  - Counter decrements each edge while nonzero.
  - On the edge where counter goes 1->0, hi<=pend_hi and lo<=pend_lo.
  - The new values are visible in the first cycle busy=0.
- HI/LO are never updated mid-operation. hi/lo hold their old values until commit.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit rs*rt.
  - MULTU: {hi,lo} = unsigned 64-bit rs*rt.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Division by zero (rt=0, DIV or DIVU):
  - The operation still occupies DIV_CYCLES of busy.
  - HI and LO stay unchanged at commit.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - When start=1 and busy=0, hi (or lo) <= rs_data at the edge. Single cycle; busy is not asserted.
- start with busy=1:
  - Ops 1-6 are ignored, with no state change.
  - The hazard unit guarantees this does not happen; the unit must still be robust to it.
- MFHI/MFLO:
  - out is purely combinational and independent of start.
  - While busy=1 it shows the old HI/LO. The hazard unit stalls reads during busy.
- NONE and codes 9-15: no state change; out=0.
- Reset asserted mid-operation: busy drops immediately (asynchronously) and HI/LO read 0.

Test Plan:
- MULT: rs=0xFFFFFFFE (-2), rt=3, start pulse.
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo hold their previous values (0) during busy.
- MULTU then DIV:
  - MULTU rs=0xFFFFFFFF, rt=2 -> hi=1, lo=0xFFFFFFFE after 5 cycles.
  - Then DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Edge divides:
  - DIVU rs=7, rt=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start while busy: launch MULT 6*7, then assert start with DIV 100/3 in busy cycle 2.
  - DIV is ignored.
  - After 5 cycles hi=0, lo=42; busy deasserts on schedule.
- MTHI/MTLO and MF reads:
  - MTHI rs=0xDEADBEEF, then MFHI next cycle -> out=0xDEADBEEF.
  - MFLO with lo=5 -> out=5.
  - mdu_op=9 -> out=0.
- Reset mid-DIV: assert reset in busy cycle 4 between clock edges.
  - busy=0, hi=lo=0 immediately.
  - After release, no stale commit occurs over the next 10 cycles.
